// File: rtl/zero_stuff_pkg.sv
// rtl/zero_stuff_pkg.sv - shared state encoding and line constants for zero_stuff_tx
//
// Purpose : types and constants shared by the zero-stuffing transmitter files.
// Contents: state_t  (IDLE=0, SHIFT=1, STUFF=2, 2-bit encoding)
//           LINE_IDLE (level the serial line rests at when nothing is sent)
package zero_stuff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/zero_stuff_tx_if.sv
// rtl/zero_stuff_tx_if.sv - word handshake and serial line bundle for zero_stuff_tx
//
// Purpose : groups the parallel input handshake and the serial line outputs.
// Signals : dataIn[WIDTH], dataValid  - word from the source
//           dataReady                 - transmitter accepts dataIn on this edge
//           outBit, outValid, stuffing - serial line, its qualifier, stuffed-bit flag
//           busy                      - transmitter not idle
// Modports: master = word source / line observer, slave = transmitter
interface zero_stuff_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dataIn;
    logic             dataValid;
    logic             dataReady;
    logic             outBit;
    logic             outValid;
    logic             stuffing;
    logic             busy;

    modport master (
        output dataIn,
        output dataValid,
        input  dataReady,
        input  outBit,
        input  outValid,
        input  stuffing,
        input  busy
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        output dataReady,
        output outBit,
        output outValid,
        output stuffing,
        output busy
    );
endinterface

// File: rtl/zero_run_tracker.sv
// rtl/zero_run_tracker.sv - consecutive-zero counter that flags when a stuff bit is due
//
// Purpose : counts consecutive data zeros seen on the line.
// Ports   : clock, reset (async active-low)
//           bit_i        - data bit currently on the line
//           valid_i      - bit_i is a data bit this cycle
//           clear_i      - line shows a one that is not data (idle or stuffed)
//           stuff_next_o - current zero completes a MAX_ZEROS run; stuff next cycle
module zero_run_tracker #(
    parameter int MAX_ZEROS = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_i,
    input  logic valid_i,
    input  logic clear_i,
    output logic stuff_next_o
);
    localparam int RW = $clog2(MAX_ZEROS + 1);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;

    // Combinational on the bit being shown now, so the FSM can pick STUFF
    // at the very edge that ends this bit.
    assign stuff_next_o = valid_i && !bit_i && (run_q == RW'(MAX_ZEROS - 1));

    always_comb begin
        run_d = run_q;
        if (clear_i) begin
            run_d = '0;
        end else if (valid_i) begin
            run_d = bit_i ? '0 : run_q + RW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/zero_stuff_tx.sv
// rtl/zero_stuff_tx.sv - zero-stuffing serial transmitter
//
// Purpose : takes WIDTH-bit words over a valid/ready handshake and sends them
//           one bit per clock, inserting a '1' after every MAX_ZEROS zeros.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - zero_stuff_tx_if.slave (dataIn/dataValid/dataReady,
//                   outBit/outValid/stuffing/busy)
module zero_stuff_tx
    import zero_stuff_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_ZEROS = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic            clock,
    input  logic            reset,
    zero_stuff_tx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;   // data bits not yet finished, incl. the one on the line in SHIFT
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             stuffing_q, stuffing_d;
    logic             reset_done_q;

    logic data_ready;
    logic accept;
    logic stuff_next;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    zero_run_tracker #(
        .MAX_ZEROS (MAX_ZEROS)
    ) u_tracker (
        .clock        (clock),
        .reset        (reset),
        .bit_i        (out_bit_q),
        .valid_i      (state_q == SHIFT),
        .clear_i      (state_q != SHIFT),
        .stuff_next_o (stuff_next)
    );

    // Ready only where the line would otherwise fall idle, so an accepted
    // word always continues the stream without a gap.
    always_comb begin
        data_ready = 1'b0;
        unique case (state_q)
            IDLE:    data_ready = 1'b1;
            SHIFT:   data_ready = (bitcnt_q == CW'(1)) && !stuff_next;
            STUFF:   data_ready = (bitcnt_q == '0);
            default: data_ready = 1'b0;
        endcase
        data_ready = data_ready && reset_done_q;
    end

    assign accept = bus.dataValid && data_ready;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bitcnt_d    = bitcnt_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
        stuffing_d  = 1'b0;

        unique case (state_q)
            SHIFT: begin
                bitcnt_d = bitcnt_q - CW'(1);
                if (stuff_next) begin
                    state_d     = STUFF;
                    out_bit_d   = 1'b1;
                    out_valid_d = 1'b1;
                    stuffing_d  = 1'b1;
                end else if (bitcnt_q > CW'(1)) begin
                    out_bit_d = first_bit(sreg_q);
                    sreg_d    = shift_word(sreg_q);
                end else begin
                    state_d     = IDLE;
                    out_bit_d   = LINE_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            STUFF: begin
                // bitcnt already excludes the bit before the stuff; the
                // next data bit keeps the count unchanged.
                if (bitcnt_q != '0) begin
                    state_d     = SHIFT;
                    out_bit_d   = first_bit(sreg_q);
                    sreg_d      = shift_word(sreg_q);
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    out_bit_d   = LINE_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_bit_d   = LINE_IDLE;
                out_valid_d = 1'b0;
                bitcnt_d    = '0;
            end
        endcase

        // A new word overrides the idle/hold choice made above; data_ready
        // guarantees this only happens where nothing else is pending.
        if (accept) begin
            state_d     = SHIFT;
            out_bit_d   = first_bit(bus.dataIn);
            sreg_d      = shift_word(bus.dataIn);
            bitcnt_d    = CW'(WIDTH);
            out_valid_d = 1'b1;
            stuffing_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            bitcnt_q     <= '0;
            out_bit_q    <= LINE_IDLE;
            out_valid_q  <= 1'b0;
            stuffing_q   <= 1'b0;
            reset_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bitcnt_q     <= bitcnt_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            stuffing_q   <= stuffing_d;
            reset_done_q <= 1'b1;
        end
    end

    assign bus.dataReady = data_ready;
    assign bus.outBit    = out_bit_q;
    assign bus.outValid  = out_valid_q;
    assign bus.stuffing  = stuffing_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_zero_stuff_tx.sv
// tb/tb_zero_stuff_tx.sv - self-checking bench for zero_stuff_tx
module tb_zero_stuff_tx;
    localparam int W  = 8;
    localparam int MZ = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    zero_stuff_tx_if #(.WIDTH(W)) bus ();

    zero_stuff_tx #(
        .WIDTH     (W),
        .MAX_ZEROS (MZ),
        .MSB_FIRST (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] words_q[$];
    logic [1:0]   exp_q[$];   // {stuffed, bit}
    logic [1:0]   got_q[$];
    int           ready_pos_q[$];
    bit           gap_seen;
    bit           timed_out;

    // Reference: send words MSB first; a run of MZ data zeros is followed by a '1'.
    function automatic void build_expected();
        int run = 0;
        exp_q.delete();
        foreach (words_q[k]) begin
            logic [W-1:0] w = words_q[k];
            for (int i = W - 1; i >= 0; i--) begin
                exp_q.push_back({1'b0, w[i]});
                run = w[i] ? 0 : run + 1;
                if (run == MZ) begin
                    exp_q.push_back(2'b11);
                    run = 0;
                end
            end
        end
    endfunction

    // Offers words_q back-to-back with dataValid held and records the line.
    task automatic run_words();
        int  idx = 0;
        int  cyc = 0;
        bit  started = 0;
        bit  ended = 0;
        bit  done = 0;
        bit  will;
        got_q.delete();
        ready_pos_q.delete();
        gap_seen  = 0;
        timed_out = 0;
        while (!done) begin
            @(negedge clock);
            cyc++;
            if (bus.outValid) begin
                got_q.push_back({bus.stuffing, bus.outBit});
                if (ended) gap_seen = 1;
                started = 1;
                if (bus.dataReady) ready_pos_q.push_back(got_q.size());
            end else if (started) begin
                ended = 1;
            end
            if (idx == words_q.size() && started && !bus.outValid && !bus.busy) begin
                done = 1;
            end else if (cyc > 200) begin
                timed_out = 1;
                done = 1;
            end
            if (done) begin
                bus.dataValid = 1'b0;
            end else begin
                bus.dataValid = (idx < words_q.size());
                bus.dataIn    = bus.dataValid ? words_q[idx] : W'($urandom);
                will = bus.dataValid && bus.dataReady;
                @(posedge clock);
                if (will) idx++;
            end
        end
    endtask

    task automatic compare_line(input string name);
        int run = 0;
        int maxrun = 0;
        build_expected();
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s timeout: stream did not return to idle", name);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s length: got %0d line bits, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s bit %0d: got {stuff,bit}=%b expected %b", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (gap_seen) begin
            errors++;
            $display("FAIL %s contiguity: outValid dropped mid-stream, expected contiguous", name);
        end
        foreach (got_q[i]) begin
            run = (got_q[i] == 2'b00) ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        checks++;
        if (maxrun > MZ) begin
            errors++;
            $display("FAIL %s zero_run: got %0d consecutive zeros, limit %0d", name, maxrun, MZ);
        end
        checks++;
        if (bus.outBit !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: outBit=%b busy=%b expected 1/0", name, bus.outBit, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.dataValid = 1'b0;
        bus.dataIn    = '0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.outBit !== 1'b1 || bus.outValid !== 1'b0 || bus.dataReady !== 1'b0 ||
            bus.busy !== 1'b0 || bus.stuffing !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outBit=%b outValid=%b dataReady=%b busy=%b stuffing=%b expected 1,0,0,0,0",
                     bus.outBit, bus.outValid, bus.dataReady, bus.busy, bus.stuffing);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.dataReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 0 before first edge", bus.dataReady);
        end
        @(negedge clock);
        checks++;
        if (bus.dataReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_done_ready: got %b expected 1", bus.dataReady);
        end
    endtask

    task automatic test_all_ones();
        words_q = {};
        words_q.push_back(8'hFF);
        run_words();
        compare_line("ones_FF");
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL ones_count: got %0d outValid cycles expected 8", got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== 2'b01) begin
                errors++;
                $display("FAIL ones_bit %0d: got %b expected 01", i, got_q[i]);
            end
        end
    endtask

    task automatic test_all_zeros();
        words_q = {};
        words_q.push_back(8'h00);
        run_words();
        compare_line("zeros_00");
        checks++;
        if (got_q.size() != 12) begin
            errors++;
            $display("FAIL zeros_count: got %0d cycles expected 12", got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i][1] !== ((i % 3) == 2)) begin
                errors++;
                $display("FAIL zeros_stuff_pos %0d: got stuffing=%b expected %b", i + 1, got_q[i][1], ((i % 3) == 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        words_q = {};
        words_q.push_back(8'hA5);
        words_q.push_back(8'h3C);
        run_words();
        compare_line("b2b_A5_3C");
        checks++;
        if (got_q.size() != 19) begin
            errors++;
            $display("FAIL b2b_count: got %0d cycles expected 19", got_q.size());
        end
        checks++;
        if (ready_pos_q.size() == 0 || ready_pos_q[0] != 9) begin
            errors++;
            $display("FAIL b2b_ready_pos: got first mid-stream ready at line bit %0d expected 9",
                     (ready_pos_q.size() == 0) ? -1 : ready_pos_q[0]);
        end
    endtask

    task automatic test_cross_word();
        words_q = {};
        words_q.push_back(8'h80);
        words_q.push_back(8'h7F);
        run_words();
        compare_line("cross_80_7F");
        checks++;
        if (got_q.size() < 13 || got_q[11] !== 2'b00 || got_q[12] !== 2'b11) begin
            errors++;
            $display("FAIL cross_stuff: got entries 11,12 = %b,%b expected 00,11",
                     (got_q.size() > 11) ? got_q[11] : 2'bxx, (got_q.size() > 12) ? got_q[12] : 2'bxx);
        end
    endtask

    task automatic test_reset_mid_word();
        @(negedge clock);
        bus.dataIn    = 8'h00;
        bus.dataValid = 1'b1;
        @(posedge clock);
        #1 bus.dataValid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_precond: outValid=%b expected 1 mid-word", bus.outValid);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.outBit !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b0 || bus.dataReady !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: outBit=%b outValid=%b busy=%b dataReady=%b expected 1,0,0,0",
                     bus.outBit, bus.outValid, bus.busy, bus.dataReady);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        words_q = {};
        words_q.push_back(8'hF0);
        run_words();
        compare_line("after_reset_F0");
        checks++;
        if (got_q.size() != 10) begin
            errors++;
            $display("FAIL after_reset_count: got %0d cycles expected 10", got_q.size());
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            int n = $urandom_range(1, 3);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clock);
                bus.dataValid = 1'b0;
                bus.dataIn    = W'($urandom);
            end
            words_q = {};
            for (int k = 0; k < n; k++) words_q.push_back(W'($urandom));
            run_words();
            compare_line($sformatf("random_burst%0d", b));
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_back_to_back();
        test_cross_word();
        test_reset_mid_word();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zero_stuff_tx.md
Name: zero_stuff_tx

Overview:
- Transmit end of the consecutive-zero serial link.
- Accepts parallel words over a valid/ready handshake and serializes them one bit per clock.
- After every run of MAX_ZEROS consecutive zeros it inserts a stuffed '1', so the line never carries a zero run longer than MAX_ZEROS.
- Output changes on the rising edge, so a downstream detector sampling on the falling edge sees stable data.

Parameters:
- WIDTH, 8: data word width; legal range >= 2.
- MAX_ZEROS, 2: longest zero run allowed on the line; legal range 1..WIDTH.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dataIn  in  WIDTH  word to transmit; held stable by the source while dataValid=1 and dataReady=0.
- dataValid  in  1  source has a word.
- dataReady  out  1  block accepts dataIn on this rising edge if dataValid=1.
- outBit  out  1  serial line, registered; idles high.
- outValid  out  1  outBit carries a data or stuffed bit this cycle.
- stuffing  out  1  current outBit is a stuffed '1'.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-word):
  - state=IDLE, outBit=1, outValid=0, stuffing=0, busy=0, zero-run count=0, bit count=0.
  - dataReady=0 while reset is low; a registered resetDone flop holds it low until the first rising edge after release.
  - Any partial word in flight is discarded; nothing resumes.
- States: IDLE, SHIFT, STUFF (2-bit encoding).
- IDLE:
  - Outputs: outBit=1, outValid=0, dataReady=1 (after resetDone).
  - zeroRun is cleared, because an idle-high line counts as a one.
  - Accept (dataValid & dataReady at the edge): load the shift register, set bitCnt=WIDTH, drive the first bit on outBit with outValid=1, go to SHIFT.
  - Latency: first bit is visible in the cycle immediately after the accepting edge.
- SHIFT, each cycle emits one data bit (outValid=1, stuffing=0):
  - A 0 bit increments zeroRun; a 1 bit clears zeroRun to 0.
  - If the emitted bit is 0 and zeroRun+1 == MAX_ZEROS, the next cycle is STUFF, including after the final bit of a word.
  - Otherwise the next data bit follows. After the final bit with no stuff pending, the next state is SHIFT with a new word (back-to-back) or IDLE.
- STUFF, one cycle:
  - Outputs: outBit=1, outValid=1, stuffing=1; zeroRun cleared.
  - Next state is SHIFT if bits remain, else a new word or IDLE.
- dataReady (combinational from registered state):
  - Asserted in IDLE.
  - Asserted in the cycle emitting the final data bit when no stuff follows.
  - Asserted in a STUFF cycle with bitCnt=0.
  - An accept in those cycles loads the next word with no gap on the line.
- zeroRun persists across back-to-back words; a zero run spanning a word boundary is counted and stuffed.
- dataValid while dataReady=0 is ignored, with no state change.
- Word cost: WIDTH cycles plus one per stuff. Worst case for MAX_ZEROS=1 is 2*WIDTH.
- Line invariant: with outValid=1, the line never shows more than MAX_ZEROS consecutive zeros.

Decomposition:
- Shared package zero_stuff_pkg:
  - State encoding constants IDLE=0, SHIFT=1, STUFF=2.
  - Line idle level constant LINE_IDLE=1.
- One sub-module, zero_run_tracker:
  - Contents: the zeroRun counter, width clog2(MAX_ZEROS+1).
  - Inputs: bit, valid, clear.
  - Output: stuffNext.
- Top level holds the FSM, shift register, bit counter and handshake.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles -> outBit=1, outValid=0, dataReady=0, busy=0; release -> dataReady=1 on the second cycle.
- 8'hFF, MAX_ZEROS=2 -> eight 1s, outValid high for exactly 8 cycles, stuffing never asserted, then IDLE with outBit=1.
- 8'h00, MAX_ZEROS=2 -> line 0,0,S,0,0,S,0,0,S,0,0,S over 12 cycles; stuffing high on cycles 3, 6, 9 and 12.
- Back-to-back 8'hA5 then 8'h3C with dataValid held, MSB first:
  - Line: 1,0,1,0,0,S,1,0,1 | 0,0,S,1,1,1,1,0,0,S.
  - 19 contiguous outValid cycles; dataReady pulses on the final 1 of A5.
- Cross-word run, MAX_ZEROS=2: 8'h80 then 8'h7F -> 8'h80 ends with zeroRun=1; the first 0 of 8'h7F triggers a stuff immediately after it.
- Reset mid-word: send 8'h00, pull reset low after 3 line cycles -> outBit=1 and outValid=0 immediately, without waiting for a clock edge. After release, 8'hF0 transmits 1,1,1,1,0,0,S,0,0,S with zeroRun starting from 0.
